// File: rtl/round_ctrl.sv
// Round sequencer for the frog game: watches the frog and hazard grids, keeps
// lives and score, and steps through the play / hit / restart / over phases.
module round_ctrl #(
   parameter int unsigned LIVES       = 3,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] frog,
   input  logic [63:0] car,
   input  logic        newGame,
   output logic        resetRound,
   output logic [1:0]  lives,
   output logic [3:0]  score,
   output logic        hitFlash,
   output logic        gameOver
);

   // state   | meaning
   // PLAY    | frog live; collisions and goal arrivals are evaluated
   // HIT     | collision flash, runs for HOLD_CYCLES cycles
   // RESTART | one-cycle resetRound pulse that respawns the frog
   // OVER    | no lives left, grid frozen, waits for newGame
   typedef enum logic [1:0] {
      PLAY    = 2'd0,
      HIT     = 2'd1,
      RESTART = 2'd2,
      OVER    = 2'd3
   } state_t;

   localparam logic [1:0] LIVES_LOAD = 2'(LIVES);
   localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
   localparam logic [3:0] SCORE_MAX  = 4'd15;

   state_t     state_q, state_nxt;
   logic [1:0] lives_q, lives_nxt;
   logic [3:0] score_q, score_nxt;
   logic [7:0] hold_q, hold_nxt;
   logic       collision;
   logic       goal;

   assign collision = |(frog & car);
   assign goal      = |frog[63:56];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= PLAY;
         lives_q <= LIVES_LOAD;
         score_q <= 4'd0;
         hold_q  <= 8'd0;
      end else begin
         state_q <= state_nxt;
         lives_q <= lives_nxt;
         score_q <= score_nxt;
         hold_q  <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      lives_nxt = lives_q;
      score_nxt = score_q;
      hold_nxt  = hold_q;
      case (state_q)
         PLAY: begin
            // a hazard on the goal row still kills the frog
            if (collision) begin
               state_nxt = HIT;
               hold_nxt  = HOLD_LOAD;
               if (lives_q != 2'd0) begin
                  lives_nxt = lives_q - 2'd1;
               end
            end else if (goal) begin
               state_nxt = RESTART;
               if (score_q != SCORE_MAX) begin
                  score_nxt = score_q + 4'd1;
               end
            end
         end
         HIT: begin
            if (hold_q == 8'd0) begin
               state_nxt = (lives_q == 2'd0) ? OVER : RESTART;
            end else begin
               hold_nxt = hold_q - 8'd1;
            end
         end
         RESTART: begin
            state_nxt = PLAY;
         end
         OVER: begin
            if (newGame) begin
               state_nxt = RESTART;
               lives_nxt = LIVES_LOAD;
               score_nxt = 4'd0;
            end
         end
         default: begin
            state_nxt = PLAY;
         end
      endcase
   end

   assign resetRound = (state_q == RESTART);
   assign hitFlash   = (state_q == HIT);
   assign gameOver   = (state_q == OVER);
   assign lives      = (state_q == OVER) ? 2'd0 : lives_q;
   assign score      = score_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: directed scenarios plus random play, checked against a
// queue-based model of the per-cycle output phase.
module tb_round_ctrl;

   localparam int LIVES = 3;
   localparam int HOLD  = 4;
   localparam int PH_HIT = 1;
   localparam int PH_RESTART = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] frog;
   logic [63:0] car;
   logic        newGame;
   logic        resetRound;
   logic [1:0]  lives;
   logic [3:0]  score;
   logic        hitFlash;
   logic        gameOver;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int m_q[$];
   int m_lives;
   int m_score;
   bit m_over;

   round_ctrl #(.LIVES(LIVES), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk),
      .reset(reset),
      .frog(frog),
      .car(car),
      .newGame(newGame),
      .resetRound(resetRound),
      .lives(lives),
      .score(score),
      .hitFlash(hitFlash),
      .gameOver(gameOver)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_lives = LIVES;
      m_score = 0;
      m_over  = 1'b0;
   endtask

   // Advance the model across one clock edge with the inputs seen at that edge.
   task automatic model_edge(input logic [63:0] f, input logic [63:0] c, input logic ng);
      if (m_q.size() != 0) begin
         void'(m_q.pop_front());
      end else if (m_over) begin
         if (ng) begin
            m_lives = LIVES;
            m_score = 0;
            m_over  = 1'b0;
            m_q.push_back(PH_RESTART);
         end
      end else if ((f & c) != 64'd0) begin
         if (m_lives > 0) m_lives--;
         for (int i = 0; i < HOLD; i++) m_q.push_back(PH_HIT);
         if (m_lives == 0) m_over = 1'b1;
         else m_q.push_back(PH_RESTART);
      end else if (f[63:56] != 8'd0) begin
         m_score = (m_score >= 15) ? 15 : m_score + 1;
         m_q.push_back(PH_RESTART);
      end
   endtask

   task automatic check_model();
      int ph;
      ph = (m_q.size() != 0) ? m_q[0] : 0;
      check("hitFlash",   {7'd0, hitFlash},   {7'd0, ph == PH_HIT});
      check("resetRound", {7'd0, resetRound}, {7'd0, ph == PH_RESTART});
      check("gameOver",   {7'd0, gameOver},   {7'd0, (m_q.size() == 0) && m_over});
      check("lives",      {6'd0, lives},      8'(m_lives));
      check("score",      {4'd0, score},      8'(m_score));
   endtask

   task automatic tick(input logic [63:0] f, input logic [63:0] c, input logic ng);
      @(negedge clk);
      frog    = f;
      car     = c;
      newGame = ng;
      @(posedge clk);
      model_edge(f, c, ng);
      #1;
      cyc++;
      check_model();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rr"},    {7'd0, resetRound}, 8'd0);
      check({tag, "_hit"},   {7'd0, hitFlash},   8'd0);
      check({tag, "_over"},  {7'd0, gameOver},   8'd0);
      check({tag, "_lives"}, {6'd0, lives},      8'(LIVES));
      check({tag, "_score"}, {4'd0, score},      8'd0);
   endtask

   function automatic logic [63:0] bit64(input int idx);
      logic [63:0] v;
      v = 64'd1 << idx;
      return v;
   endfunction

   initial begin
      logic [63:0] f, c;
      reset   = 1'b1;
      frog    = 64'd0;
      car     = 64'd0;
      newGame = 1'b0;
      model_reset();
      #2;
      check_reset_vals("reset_init");
      @(negedge clk);
      reset = 1'b0;

      // goal on row 7
      tick(bit64(59), 64'd0, 1'b0);
      tick(64'd0, 64'd0, 1'b0);
      tick(64'd0, 64'd0, 1'b0);

      // collision; grid inputs held colliding while HIT ignores them
      for (int i = 0; i < HOLD + 1; i++) tick(bit64(10), bit64(10), 1'b0);
      tick(64'd0, 64'd0, 1'b0);
      tick(64'd0, 64'd0, 1'b0);

      // collision on the goal row wins over the goal
      tick(bit64(60), bit64(60), 1'b0);
      for (int i = 0; i < HOLD + 2; i++) tick(64'd0, 64'd0, i == 1);

      // last life lost, then game over and new game
      tick(bit64(20), bit64(20) | bit64(3), 1'b0);
      for (int i = 0; i < HOLD + 3; i++) tick(64'd0, 64'd0, 1'b0);
      tick(64'd0, 64'd0, 1'b1);
      tick(64'd0, 64'd0, 1'b0);
      tick(64'd0, 64'd0, 1'b1);
      tick(64'd0, 64'd0, 1'b1);
      tick(bit64(5), 64'd0, 1'b1);

      // sixteen goals in a row saturate the score
      for (int i = 0; i < 16; i++) begin
         tick(bit64(56 + (i % 8)), 64'd0, 1'b0);
         tick(64'd0, 64'd0, 1'b0);
      end

      // random play
      for (int i = 0; i < 400; i++) begin
         f = ($urandom_range(0, 9) == 0) ? 64'd0 : bit64($urandom_range(0, 63));
         c = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         tick(f, c, $urandom_range(0, 3) == 0);
      end

      // async reset in the middle of HIT
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      tick(bit64(30), bit64(30), 1'b0);
      tick(64'd0, 64'd0, 1'b0);
      check("midhit_flash", {7'd0, hitFlash}, 8'd1);
      #3;
      reset = 1'b1;
      #1;
      check_reset_vals("async");
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < HOLD + 2; i++) tick(64'd0, 64'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
